// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared DLX fetch definitions.
//   - fetch FSM state encoding (IDLE / RUN / HALTED)
//   - PC increment per fetched word, instruction width, default reset PC
package instr_fetch_pkg;

  localparam int          INSTR_WIDTH  = 32;
  localparam int          PC_INCR      = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch-stage bus bundle.
//   ROM side : rom_rd_ena / rom_address (to ROM), rom_data (from ROM,
//              valid one cycle after a read)
//   IF/ID    : instr / instr_pc / instr_valid (to the IF/ID register)
//   master = fetch stage, slave = ROM + IF/ID consumer.
interface instr_fetch_if #(
  parameter int PC_WIDTH       = 32,
  parameter int ROM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 32
);
  logic                      rom_rd_ena;
  logic [ROM_ADDR_WIDTH-1:0] rom_address;
  logic [DATA_WIDTH-1:0]     rom_data;
  logic [DATA_WIDTH-1:0]     instr;
  logic [PC_WIDTH-1:0]       instr_pc;
  logic                      instr_valid;

  modport master (
    output rom_rd_ena, rom_address, instr, instr_pc, instr_valid,
    input  rom_data
  );

  modport slave (
    input  rom_rd_ena, rom_address, instr, instr_pc, instr_valid,
    output rom_data
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: DLX fetch stage.
//   Owns the program counter, drives the 1-cycle registered instruction ROM
//   and tags each returned word with its byte PC and a valid bit.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 pulse: IDLE -> RUN
//   halt                  pulse from decode: RUN -> HALTED (exit by reset only)
//   stall                 freeze fetch (ROM read suppressed so data holds)
//   branch_taken/target   redirect from EX (target low two bits ignored)
//   halted                high in HALTED
//   bus (master)          ROM address/read/data + instr/instr_pc/instr_valid
// Event priority in RUN: halt > branch_taken > stall.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                  PC_WIDTH       = 32,
  parameter int                  ROM_ADDR_WIDTH = 10,
  parameter int                  DATA_WIDTH     = INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC       = PC_WIDTH'(RESET_PC_DEF)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                halt,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                halted,
  instr_fetch_if.master       bus
);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc, out_pc;
  logic                out_valid;

  // per-cycle datapath controls decoded from state + events
  logic advance;   // read ROM at fetch_pc and step the PC
  logic redirect;  // load fetch_pc from branch target
  logic kill;      // clear out_valid at the edge

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_RUN;
      ST_RUN:    if (halt)  state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs / controls ----------------
  always_comb begin
    advance  = 1'b0;
    redirect = 1'b0;
    kill     = 1'b0;
    if (state_q == ST_RUN) begin
      if (halt) begin
        kill = 1'b1;
      end else if (branch_taken) begin
        // the wrong-path word already in IF/ID is squashed by decode
        redirect = 1'b1;
        kill     = 1'b1;
      end else if (!stall) begin
        advance = 1'b1;
      end
    end
  end

  // ---------------- PC / tag registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      out_pc    <= RESET_PC;
      out_valid <= 1'b0;
    end else begin
      if (redirect) begin
        fetch_pc <= branch_target & ~PC_WIDTH'(3);
      end else if (advance) begin
        out_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + PC_WIDTH'(PC_INCR); // wraps mod 2^PC_WIDTH
      end
      if (kill)         out_valid <= 1'b0;
      else if (advance) out_valid <= 1'b1;
    end
  end

  // ROM read only when the fetch actually advances; with rd_ena low the ROM
  // holds its output, which keeps instr stable through a stall.
  assign bus.rom_rd_ena  = advance;
  // word index; truncation wraps within the ROM by design
  assign bus.rom_address = fetch_pc[ROM_ADDR_WIDTH+1:2];

  assign bus.instr       = bus.rom_data;
  assign bus.instr_pc    = out_pc;
  assign bus.instr_valid = out_valid;
  assign halted          = (state_q == ST_HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, halt = 1'b0, stall = 1'b0, br = 1'b0;
  logic [31:0] tgt = '0;
  logic        halted;

  int checks = 0;
  int errors = 0;

  instr_fetch_if #(.PC_WIDTH(32), .ROM_ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  instr_fetch #(.PC_WIDTH(32), .ROM_ADDR_WIDTH(AW), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .stall(stall),
    .branch_taken(br), .branch_target(tgt), .halted(halted), .bus(bus)
  );

  always #5 clk = ~clk;

  // instruction ROM: 1-cycle registered read, holds data when not read
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (bus.rom_rd_ena) bus.rom_data <= mem[bus.rom_address];

  // ---------------- reference model ----------------
  // running/halted flags, next address to fetch, and the tag of the word
  // the ROM currently presents.
  logic        m_run, m_halt, m_ov;
  logic [31:0] m_fpc, m_opc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 0; m_halt <= 0; m_ov <= 0; m_fpc <= 0; m_opc <= 0;
    end else if (m_run) begin
      if (halt) begin
        m_run <= 0; m_halt <= 1; m_ov <= 0;
      end else if (br) begin
        m_fpc <= {tgt[31:2], 2'b00}; m_ov <= 0;
      end else if (!stall) begin
        m_opc <= m_fpc; m_fpc <= m_fpc + 32'd4; m_ov <= 1;
      end
    end else if (!m_halt && start) begin
      m_run <= 1;
    end
  end

  logic          e_rd;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_instr;
  always_comb begin
    e_rd    = m_run && !halt && !br && !stall;
    e_addr  = m_fpc[AW+1:2];
    e_instr = mem[m_opc[AW+1:2]];
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic s, input logic h, input logic st,
                       input logic b, input logic [31:0] t);
    @(posedge clk); #1;
    start = s; halt = h; stall = st; br = b; tgt = t;
    @(negedge clk);
  endtask

  task automatic reset_start();
    rst_n = 0; start = 0; halt = 0; stall = 0; br = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    drive(1, 0, 0, 0, 0);   // start pulse in IDLE
    drive(0, 0, 0, 0, 0);   // first fetch of RESET_PC
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    @(negedge clk);
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.instr_valid); end
    checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", bus.instr_pc); end
    checks++; if (bus.rom_rd_ena !== 1'b0) begin errors++; $display("FAIL reset_rd got=%b exp=0", bus.rom_rd_ena); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    rst_n = 1;
    drive(0, 0, 0, 0, 0);
    checks++; if (bus.rom_rd_ena !== 1'b0) begin errors++; $display("FAIL idle_rd got=%b exp=0", bus.rom_rd_ena); end
  endtask

  task automatic test_sequential();
    reset_start();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0);
      checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d got=%b exp=1", k, bus.instr_valid); end
      checks++; if (bus.instr_pc !== 32'(4*k)) begin errors++; $display("FAIL seq_pc%0d got=%h exp=%h", k, bus.instr_pc, 32'(4*k)); end
      checks++; if (bus.instr !== mem[k]) begin errors++; $display("FAIL seq_instr%0d got=%h exp=%h", k, bus.instr, mem[k]); end
    end
  endtask

  task automatic test_stall();
    reset_start();
    drive(0, 0, 0, 0, 0);   // A/0 visible
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 0, 0);
      checks++; if (bus.rom_rd_ena !== 1'b0) begin errors++; $display("FAIL stall_rd%0d got=%b exp=0", k, bus.rom_rd_ena); end
      checks++; if (bus.instr !== mem[1] || bus.instr_pc !== 32'h4 || bus.instr_valid !== 1'b1)
        begin errors++; $display("FAIL stall_hold%0d got=%h/%h/%b exp=%h/00000004/1", k, bus.instr, bus.instr_pc, bus.instr_valid, mem[1]); end
    end
    drive(0, 0, 0, 0, 0);
    checks++; if (bus.instr_pc !== 32'h4 || bus.rom_address !== 10'd2) begin errors++; $display("FAIL stall_release got=%h/%h exp=00000004/002", bus.instr_pc, bus.rom_address); end
    drive(0, 0, 0, 0, 0);
    checks++; if (bus.instr !== mem[2] || bus.instr_pc !== 32'h8) begin errors++; $display("FAIL stall_next got=%h/%h exp=%h/00000008", bus.instr, bus.instr_pc, mem[2]); end
  endtask

  task automatic test_branch();
    reset_start();
    repeat (3) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h42);   // fetch_pc = 0x10 here
    checks++; if (bus.rom_address !== 10'd4 || bus.rom_rd_ena !== 1'b0) begin errors++; $display("FAIL br_cycle got=%h/%b exp=004/0", bus.rom_address, bus.rom_rd_ena); end
    drive(0, 0, 0, 0, 0);
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL br_bubble got=%b exp=0", bus.instr_valid); end
    checks++; if (bus.rom_address !== 10'd16) begin errors++; $display("FAIL br_addr got=%h exp=010", bus.rom_address); end
    drive(0, 0, 0, 0, 0);
    checks++; if (bus.instr !== mem[16] || bus.instr_pc !== 32'h40 || bus.instr_valid !== 1'b1)
      begin errors++; $display("FAIL br_target got=%h/%h/%b exp=%h/00000040/1", bus.instr, bus.instr_pc, bus.instr_valid, mem[16]); end
  endtask

  task automatic test_branch_stall();
    reset_start();
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 32'h83);
    drive(0, 0, 0, 0, 0);
    checks++; if (bus.instr_valid !== 1'b0 || bus.rom_address !== 10'd32)
      begin errors++; $display("FAIL brst_redirect got=%b/%h exp=0/020", bus.instr_valid, bus.rom_address); end
    drive(0, 0, 0, 0, 0);
    checks++; if (bus.instr !== mem[32] || bus.instr_pc !== 32'h80) begin errors++; $display("FAIL brst_target got=%h/%h exp=%h/00000080", bus.instr, bus.instr_pc, mem[32]); end
  endtask

  task automatic test_halt();
    reset_start();
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 32'h100);
    checks++; if (bus.rom_rd_ena !== 1'b0) begin errors++; $display("FAIL halt_rd got=%b exp=0", bus.rom_rd_ena); end
    drive(0, 0, 0, 0, 0);
    checks++; if (halted !== 1'b1 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL halt_state got=%b/%b exp=1/0", halted, bus.instr_valid); end
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h200);
    drive(0, 0, 0, 0, 0);
    checks++; if (halted !== 1'b1 || bus.instr_valid !== 1'b0 || bus.rom_rd_ena !== 1'b0)
      begin errors++; $display("FAIL halt_sticky got=%b/%b/%b exp=1/0/0", halted, bus.instr_valid, bus.rom_rd_ena); end
  endtask

  task automatic test_async_reset_wrap();
    reset_start();
    repeat (2) drive(0, 0, 0, 0, 0);
    #2 rst_n = 0;   // between edges
    #1;
    checks++; if (bus.instr_valid !== 1'b0 || bus.instr_pc !== 32'h0 || bus.rom_rd_ena !== 1'b0)
      begin errors++; $display("FAIL async_rst got=%b/%h/%b exp=0/00000000/0", bus.instr_valid, bus.instr_pc, bus.rom_rd_ena); end
    @(negedge clk); rst_n = 1;
    drive(0, 0, 0, 0, 0);
    checks++; if (bus.rom_rd_ena !== 1'b0) begin errors++; $display("FAIL rst_idle got=%b exp=0", bus.rom_rd_ena); end
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'hFFC);
    drive(0, 0, 0, 0, 0);
    checks++; if (bus.rom_address !== 10'h3FF) begin errors++; $display("FAIL wrap_addr0 got=%h exp=3ff", bus.rom_address); end
    drive(0, 0, 0, 0, 0);
    checks++; if (bus.rom_address !== 10'h0 || bus.instr !== mem[1023] || bus.instr_pc !== 32'hFFC)
      begin errors++; $display("FAIL wrap_step got=%h/%h/%h exp=000/%h/00000ffc", bus.rom_address, bus.instr, bus.instr_pc, mem[1023]); end
    drive(0, 0, 0, 0, 0);
    checks++; if (bus.instr !== mem[0] || bus.instr_pc !== 32'h1000) begin errors++; $display("FAIL wrap_pc got=%h/%h exp=%h/00001000", bus.instr, bus.instr_pc, mem[0]); end
  endtask

  task automatic test_random();
    logic [31:0] t;
    reset_start();
    for (int i = 0; i < 600; i++) begin
      if (m_halt) reset_start();
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 60) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 5) == 0, t);
      checks++; if (bus.rom_rd_ena !== e_rd) begin errors++; $display("FAIL rnd_rd@%0d got=%b exp=%b", i, bus.rom_rd_ena, e_rd); end
      checks++; if (bus.rom_address !== e_addr) begin errors++; $display("FAIL rnd_addr@%0d got=%h exp=%h", i, bus.rom_address, e_addr); end
      checks++; if (bus.instr_valid !== m_ov) begin errors++; $display("FAIL rnd_valid@%0d got=%b exp=%b", i, bus.instr_valid, m_ov); end
      checks++; if (bus.instr_pc !== m_opc) begin errors++; $display("FAIL rnd_pc@%0d got=%h exp=%h", i, bus.instr_pc, m_opc); end
      checks++; if (halted !== m_halt) begin errors++; $display("FAIL rnd_halted@%0d got=%b exp=%b", i, halted, m_halt); end
      if (m_ov) begin
        checks++; if (bus.instr !== e_instr) begin errors++; $display("FAIL rnd_instr@%0d got=%h exp=%h", i, bus.instr, e_instr); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_stall();
    test_halt();
    test_async_reset_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
